int_rx: RTL
===========

INT_RX -- requirements
Module: int_rx

Interface
REQ-001 Parameters SHALL be: CLK_MHZ, default 100, clock frequency in MHz; PW_MAX_US, default 200, maximum on-time in µs; OFF_MIN_US, default 1000, minimum off-time in µs; GLITCH_CYC, default 3, deglitch length in clocks.
REQ-002 Ports SHALL be: clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 int_in  input  1  raw interrupter pulse from the fibre receiver, asynchronous to clk.
REQ-005 en  output  1  registered gate-enable for the bridge driver.
REQ-006 trunc  output  1  one-clock pulse: on-time cut at PW_MAX_US.
REQ-007 drop  output  1  one-clock pulse: rising edge rejected during holdoff.
REQ-008 pw_us  output  8  last accepted on-time in µs, saturating at 255.

Function
REQ-009 int_in SHALL pass through a 2-FF synchronizer and then a deglitch filter; the filtered level changes only after GLITCH_CYC consecutive equal synchronized samples.
REQ-010 The FSM SHALL have states IDLE, ON and HOLDOFF, with reset state IDLE.
REQ-011 IDLE: a filtered rising edge SHALL move the FSM to ON and set en=1; en rises exactly GLITCH_CYC+3 clocks after int_in rises.
REQ-012 IDLE: a filtered level that is already high without an edge SHALL NOT start ON, and the block SHALL wait for a low level followed by a rising edge.
REQ-013 ON: the on-counter SHALL count from 0, and a filtered falling edge SHALL clear en and move to HOLDOFF, so that en falls GLITCH_CYC+3 clocks after int_in falls.
REQ-014 ON: when the on-counter reaches PW_MAX_US*CLK_MHZ, the block SHALL clear en the next clock, pulse trunc for 1 clock and enter HOLDOFF, even if the input is still high.
REQ-015 If a falling edge and the PW_MAX_US limit occur on the same clock, the limit SHALL win: trunc=1 and pw_us=PW_MAX_US.
REQ-016 HOLDOFF: the off-counter SHALL run OFF_MIN_US*CLK_MHZ clocks from the en fall, and then the FSM SHALL return to IDLE.
REQ-017 HOLDOFF: every filtered rising edge SHALL be ignored and SHALL pulse drop for 1 clock, with en held at 0.
REQ-018 A rising edge on the same clock as holdoff expiry SHALL count as dropped, and REQ-012 then applies.
REQ-019 A µs prescaler (modulo CLK_MHZ) SHALL count whole µs while in ON, and pw_us SHALL latch that count, saturated to 255, on the clock en falls.
REQ-020 Counter widths SHALL be $clog2 of the maximum count plus 1, and no counter SHALL wrap.

Reset
REQ-021 While rst_n=0: en=0, trunc=0, drop=0, pw_us=0, state=IDLE, counters=0, synchronizer and filter cleared to low.
REQ-022 Reset asserted mid-ON SHALL drop en asynchronously in the same instant.
REQ-023 After reset release, a high int_in SHALL require a fresh rising edge, per REQ-012.

Configuration
REQ-024 The macro INT_RX_PW_MEAS_EN SHALL control pulse-width measurement.
REQ-025 With INT_RX_PW_MEAS_EN defined, the prescaler and pw_us logic SHALL be present and behave as in REQ-019.
REQ-026 Without INT_RX_PW_MEAS_EN, pw_us SHALL be tied to 0, no prescaler logic SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-027 Package int_rx_pkg SHALL hold the state enum (IDLE, ON, HOLDOFF) and the pw_us width constant (8).
REQ-028 One sub-module, int_rx_filt, SHALL hold the synchronizer and deglitch filter, taking clk, rst_n and raw input and producing the filtered level plus 1-clock rise and fall strobes.
REQ-029 The FSM, counters and outputs SHALL reside in int_rx.

Verification (defaults, CLK_MHZ=100)
REQ-030 50 µs pulse on int_in -> en rises 6 clocks after input and stays high 5000 clocks, trunc=0, pw_us=50.
REQ-031 300 µs pulse -> en high exactly 20000 clocks, trunc pulses once, pw_us=200, and en stays low until the input goes low and rises again after holdoff.
REQ-032 2-clock high glitch, then a 3-clock high glitch -> first gives no en; second gives en after 6 clocks.
REQ-033 10 µs pulse, second pulse rising 500 µs after en falls, third pulse rising 1100 µs after en falls -> second gives drop=1 once with en=0; third is accepted.
REQ-034 rst_n pulsed low 20 µs into a 50 µs pulse -> en=0 immediately and no en for the rest of that pulse; the next clean pulse is accepted.
REQ-035 Build without INT_RX_PW_MEAS_EN and rerun REQ-030 -> identical en and trunc behaviour, pw_us=0.

Source files
------------

// File: rtl/int_rx_pkg.sv
// Shared types and helpers for the interrupter receiver.
package int_rx_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ON      = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   localparam int unsigned PW_W = 8;

   // Counter width large enough to hold max_cnt itself.
   function automatic int unsigned cnt_w(input int unsigned max_cnt);
      return $clog2(max_cnt) + 1;
   endfunction

endpackage

// File: rtl/int_rx_filt.sv
// Two-flop synchronizer plus deglitch filter with registered edge strobes.
module int_rx_filt
   import int_rx_pkg::*;
#(
   parameter int unsigned GLITCH_CYC = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic lvl,
   output logic rise,
   output logic fall
);

   localparam int unsigned CW = cnt_w(GLITCH_CYC);

   logic [1:0]    sync_q, sync_d;
   logic          lvl_q, lvl_d;
   logic          valid_q, valid_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   // Until a stable low has been seen after reset no edges are reported,
   // so an input already high at reset release cannot look like a rise.
   always_comb begin
      sync_d  = {sync_q[0], raw};
      lvl_d   = lvl_q;
      valid_d = valid_q;
      cnt_d   = '0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (!valid_q) begin
         if (!sync_q[1]) begin
            if (cnt_q == CW'(GLITCH_CYC - 1)) valid_d = 1'b1;
            else                              cnt_d   = cnt_q + 1'b1;
         end
      end else if (sync_q[1] != lvl_q) begin
         if (cnt_q == CW'(GLITCH_CYC - 1)) begin
            lvl_d  = sync_q[1];
            rise_d = sync_q[1];
            fall_d = !sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         lvl_q   <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         lvl_q   <= lvl_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign lvl  = lvl_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/int_rx.sv
// Interrupter receiver: gate-enable FSM with on-time limit and off-time holdoff.
// Define INT_RX_PW_MEAS_EN to include the pulse-width measurement (pw_us).
module int_rx
   import int_rx_pkg::*;
#(
   parameter int unsigned CLK_MHZ    = 100,
   parameter int unsigned PW_MAX_US  = 200,
   parameter int unsigned OFF_MIN_US = 1000,
   parameter int unsigned GLITCH_CYC = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            int_in,
   output logic            en,
   output logic            trunc,
   output logic            drop,
   output logic [PW_W-1:0] pw_us
);

   localparam int unsigned ON_MAX  = PW_MAX_US * CLK_MHZ;
   localparam int unsigned OFF_MAX = OFF_MIN_US * CLK_MHZ;
   localparam int unsigned ON_W    = cnt_w(ON_MAX);
   localparam int unsigned OFF_W   = cnt_w(OFF_MAX);

   state_t           state_q, state_d;
   logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
   logic [OFF_W-1:0] off_cnt_q, off_cnt_d;
   logic             en_q, en_d;
   logic             trunc_q, trunc_d;
   logic             drop_q, drop_d;
   logic             en_fall;
   logic             f_lvl, f_rise, f_fall;

   int_rx_filt #(.GLITCH_CYC(GLITCH_CYC)) u_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (int_in),
      .lvl   (f_lvl),
      .rise  (f_rise),
      .fall  (f_fall)
   );

   always_comb begin
      state_d   = state_q;
      on_cnt_d  = on_cnt_q;
      off_cnt_d = off_cnt_q;
      en_d      = en_q;
      trunc_d   = 1'b0;
      drop_d    = 1'b0;
      en_fall   = 1'b0;
      case (state_q)
         IDLE: begin
            on_cnt_d  = '0;
            off_cnt_d = '0;
            if (f_rise && f_lvl) begin
               state_d = ON;
               en_d    = 1'b1;
            end
         end
         ON: begin
            on_cnt_d = on_cnt_q + 1'b1;
            // Limit has priority over a coincident falling edge.
            if (on_cnt_d == ON_W'(ON_MAX)) begin
               trunc_d = 1'b1;
               en_fall = 1'b1;
            end else if (f_fall) begin
               en_fall = 1'b1;
            end
            if (en_fall) begin
               state_d   = HOLDOFF;
               en_d      = 1'b0;
               off_cnt_d = '0;
            end
         end
         HOLDOFF: begin
            drop_d    = f_rise;
            off_cnt_d = off_cnt_q + 1'b1;
            if (off_cnt_d == OFF_W'(OFF_MAX)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         on_cnt_q  <= '0;
         off_cnt_q <= '0;
         en_q      <= 1'b0;
         trunc_q   <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         on_cnt_q  <= on_cnt_d;
         off_cnt_q <= off_cnt_d;
         en_q      <= en_d;
         trunc_q   <= trunc_d;
         drop_q    <= drop_d;
      end
   end

   assign en    = en_q;
   assign trunc = trunc_q;
   assign drop  = drop_q;

`ifdef INT_RX_PW_MEAS_EN
   localparam int unsigned PRE_W = cnt_w(CLK_MHZ);
   localparam int unsigned US_W  = cnt_w(PW_MAX_US);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [US_W-1:0]  us_q, us_d;
   logic [PW_W-1:0]  pw_q, pw_d;

   // pw latches the count including the clock on which en falls.
   always_comb begin
      pre_d = '0;
      us_d  = '0;
      pw_d  = pw_q;
      if (state_q == ON) begin
         if (pre_q == PRE_W'(CLK_MHZ - 1)) begin
            us_d = us_q + 1'b1;
         end else begin
            pre_d = pre_q + 1'b1;
            us_d  = us_q;
         end
      end
      if (en_fall) pw_d = (32'(us_d) > 32'd255) ? '1 : PW_W'(us_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         us_q  <= '0;
         pw_q  <= '0;
      end else begin
         pre_q <= pre_d;
         us_q  <= us_d;
         pw_q  <= pw_d;
      end
   end

   assign pw_us = pw_q;
`else
   assign pw_us = '0;
`endif

endmodule
